// File: rtl/modexp_controller_pkg.sv
// modexp_controller_pkg: one-hot state encodings and width helper for the modexp sequencer
package modexp_controller_pkg;
  localparam int MC_STATE_SIZE = 6;
  typedef enum logic [MC_STATE_SIZE-1:0] {
    MC_IDLE     = 6'b000001,
    MC_NEXT     = 6'b000010,
    MC_SQ_SETUP = 6'b000100,
    MC_SQ_RUN   = 6'b001000,
    MC_MU_SETUP = 6'b010000,
    MC_MU_RUN   = 6'b100000
  } mc_state_e;
  function automatic int mc_logn(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/modexp_controller.sv
// modexp_controller: left-to-right square-and-multiply sequencer driving a modular multiplier
module modexp_controller
  import modexp_controller_pkg::*;
#(
  parameter int N = 1024,
  localparam int LOGN = mc_logn(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [N-1:0]    base_i,
  input  logic [N-1:0]    exponent_i,
  input  logic [LOGN:0]   exp_bits_i,
  input  logic [LOGN:0]   k_i,
  output logic [N-1:0]    result_o,
  output logic            done_o,
  output logic [LOGN+1:0] mul_count_o,
  output logic            mul_reset_o,
  output logic [N-1:0]    mul_a_o,
  output logic [N-1:0]    mul_b_o,
  output logic [LOGN:0]   mul_k_o,
  input  logic [N-1:0]    mul_result_i,
  input  logic            mul_done_i
);
  mc_state_e       state_q;
  logic [N-1:0]    base_q, exp_q, acc_q, result_q;
  logic [LOGN:0]   k_q, i_q, i_m1;
  logic [LOGN+1:0] cnt_q;
  logic            one_q, ready_q, done_q, mul_reset_q, cur_bit;
  // i counts remaining bits, so the bit being worked on is exponent[i-1]
  assign i_m1 = i_q - (LOGN+1)'(1);
  assign cur_bit = exp_q[LOGN'(i_m1)];
  assign ready_o = ready_q;
  assign done_o = done_q;
  assign result_o = result_q;
  assign mul_count_o = cnt_q;
  assign mul_reset_o = mul_reset_q;
  assign mul_a_o = acc_q;
  assign mul_b_o = (state_q == MC_MU_SETUP || state_q == MC_MU_RUN) ? base_q : acc_q;
  assign mul_k_o = k_q;
  // sequencer: leading-one skip, then one square per bit plus a multiply for each set bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MC_IDLE;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      result_q <= '0;
      cnt_q <= '0;
      mul_reset_q <= 1'b1;
      acc_q <= N'(1);
      i_q <= '0;
      one_q <= 1'b1;
      base_q <= '0;
      exp_q <= '0;
      k_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MC_IDLE: if (start_i) begin
          base_q <= base_i;
          exp_q <= exponent_i;
          k_q <= k_i;
          i_q <= exp_bits_i;
          acc_q <= N'(1);
          one_q <= 1'b1;
          cnt_q <= '0;
          ready_q <= 1'b0;
          state_q <= MC_NEXT;
        end
        MC_NEXT: if (i_q == '0) begin
          result_q <= acc_q;
          done_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= MC_IDLE;
        end else if (one_q) begin
          if (cur_bit) begin
            acc_q <= base_q;
            one_q <= 1'b0;
          end
          i_q <= i_m1;
        end else begin
          state_q <= MC_SQ_SETUP;
        end
        MC_SQ_SETUP: begin
          mul_reset_q <= 1'b0;
          cnt_q <= cnt_q + (LOGN+2)'(1);
          state_q <= MC_SQ_RUN;
        end
        MC_SQ_RUN: if (mul_done_i) begin
          acc_q <= mul_result_i;
          mul_reset_q <= 1'b1;
          if (cur_bit) state_q <= MC_MU_SETUP;
          else begin
            i_q <= i_m1;
            state_q <= MC_NEXT;
          end
        end
        MC_MU_SETUP: begin
          mul_reset_q <= 1'b0;
          cnt_q <= cnt_q + (LOGN+2)'(1);
          state_q <= MC_MU_RUN;
        end
        MC_MU_RUN: if (mul_done_i) begin
          acc_q <= mul_result_i;
          mul_reset_q <= 1'b1;
          i_q <= i_m1;
          state_q <= MC_NEXT;
        end
        default: begin
          mul_reset_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= MC_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_controller.sv
// tb_modexp_controller: directed and random jobs against a multiplier stub and a pow-mod reference
module tb_modexp_controller;
  localparam int N = 8;
  localparam int LOGN = 3;
  localparam int R = 13;
  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic ready_o, done_o, mul_reset_o, mul_done_i = 1'b0;
  logic [N-1:0] base_i = '0, exponent_i = '0, result_o, mul_a_o, mul_b_o, mul_result_i = '0;
  logic [LOGN:0] exp_bits_i = '0, k_i = '0, mul_k_o;
  logic [LOGN+1:0] mul_count_o;
  int n_assert = 0, n_fail = 0;
  int done_cnt = 0, low_cycles = 0, low_falls = 0, bad_overlap = 0;
  logic prev_mr = 1'b1;
  int lat_fix = 7;
  bit lat_rand = 1'b0;
  logic busy = 1'b0, fired = 1'b0;
  int cnt = 0;
  logic [N-1:0] sa = '0, sb = '0;

  modexp_controller #(.N(N)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
    .base_i(base_i), .exponent_i(exponent_i), .exp_bits_i(exp_bits_i), .k_i(k_i),
    .result_o(result_o), .done_o(done_o), .mul_count_o(mul_count_o),
    .mul_reset_o(mul_reset_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_k_o(mul_k_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
  );

  always #5 clk = ~clk;

  // multiplier stub: samples operands on the first edge out of reset, answers after a latency
  always @(posedge clk) begin
    if (mul_reset_o) begin
      busy <= 1'b0;
      fired <= 1'b0;
      mul_done_i <= 1'b0;
    end else if (!busy && !fired) begin
      busy <= 1'b1;
      fired <= 1'b1;
      sa <= mul_a_o;
      sb <= mul_b_o;
      cnt <= lat_rand ? int'($urandom_range(1, 20)) : lat_fix;
    end else if (busy) begin
      if (cnt <= 1) begin
        busy <= 1'b0;
        mul_done_i <= 1'b1;
        mul_result_i <= N'((int'(sa) * int'(sb)) % R);
      end else cnt <= cnt - 1;
    end else mul_done_i <= 1'b0;
  end

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (!mul_reset_o) low_cycles++;
    if (prev_mr && !mul_reset_o) low_falls++;
    if (!mul_reset_o && (ready_o || done_o)) bad_overlap++;
    prev_mr = mul_reset_o;
  end

  function automatic int ref_pow(input int b, input int e, input int nb);
    int ee = e & ((1 << nb) - 1);
    int r = 1;
    for (int j = 0; j < ee; j++) r = (r * b) % R;
    return r;
  endfunction

  function automatic int ref_ops(input int e, input int nb);
    int ee = e & ((1 << nb) - 1);
    int len = 0;
    int pop = 0;
    if (ee == 0) return 0;
    for (int j = 0; j < 31; j++) if (((ee >> j) & 1) == 1) begin
      len = j + 1;
      pop++;
    end
    return (len - 1) + (pop - 1);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_job(input int b, input int e, input int nb, output int cyc);
    logic [LOGN:0] kk;
    kk = (LOGN+1)'($urandom);
    base_i = N'(b);
    exponent_i = N'(e);
    exp_bits_i = (LOGN+1)'(nb);
    k_i = kk;
    done_cnt = 0;
    low_cycles = 0;
    low_falls = 0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k_i = ~kk;
    check("accepted", ready_o, 0);
    check("mul_k", mul_k_o, kk);
    cyc = 1;
    while (!done_o && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_o, 1);
  endtask

  task automatic check_job(input string t, input int er, input int ec);
    check({t, "_ready"}, ready_o, 1);
    check({t, "_result"}, result_o, er);
    check({t, "_count"}, mul_count_o, ec);
    @(negedge clk);
    check({t, "_pulse"}, done_o, 0);
    check({t, "_done_cnt"}, done_cnt, 1);
    check({t, "_held"}, result_o, er);
  endtask

  initial begin
    int cyc, b, e, nb;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_count", mul_count_o, 0);
    check("rst_mul_reset", mul_reset_o, 1);
    check("rst_mul_a", mul_a_o, 1);
    check("rst_mul_b", mul_b_o, 1);
    rst_ni = 1'b1;
    @(negedge clk);

    do_job(3, 5, 3, cyc);
    check_job("t1", 9, 3);
    check("t1_low_falls", low_falls, 3);
    check("t1_low_cycles", low_cycles, 3 * (lat_fix + 2));

    do_job(2, 'hFF, 8, cyc);
    check_job("t2", 8, 14);
    check("t2_low_falls", low_falls, 14);
    check("t2_low_cycles", low_cycles, 14 * (lat_fix + 2));

    do_job(7, 0, 0, cyc);
    check("t3_latency0", cyc, 2);
    check_job("t3", 1, 0);
    do_job(7, 0, 3, cyc);
    check("t3_latency3", cyc, 5);
    check_job("t3b", 1, 0);
    check("t3b_low_falls", low_falls, 0);
    do_job(5, 'hAB, 0, cyc);
    check_job("t3c", 1, 0);

    do_job(5, 'hF3, 2, cyc);
    check_job("t4", 8, 2);

    base_i = 8'd3;
    exponent_i = 8'd5;
    exp_bits_i = 4'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (mul_reset_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_in_run", mul_reset_o, 0);
    done_cnt = 0;
    #2 rst_ni = 1'b0;
    #1;
    check("t5_ready", ready_o, 1);
    check("t5_mul_reset", mul_reset_o, 1);
    check("t5_done", done_o, 0);
    check("t5_result", result_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    do_job(3, 5, 3, cyc);
    check_job("t5_fresh", 9, 3);

    lat_rand = 1'b1;
    b = int'($urandom_range(0, R - 1));
    e = int'($urandom_range(0, 255));
    nb = int'($urandom_range(0, N));
    base_i = N'(b);
    exponent_i = N'(e);
    exp_bits_i = (LOGN+1)'(nb);
    start_i = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("rand_accept", ready_o, 0);
      check("rand_no_done", done_o, 0);
      cyc = 0;
      while (!done_o && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      check("rand_done_seen", done_o, 1);
      check("rand_result", result_o, ref_pow(b, e, nb));
      check("rand_count", mul_count_o, ref_ops(e, nb));
      b = int'($urandom_range(0, R - 1));
      e = int'($urandom_range(0, 255));
      nb = int'($urandom_range(0, N));
      base_i = N'(b);
      exponent_i = N'(e);
      exp_bits_i = (LOGN+1)'(nb);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("overlap", bad_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
